// File: rtl/qsf_pkg.sv
// Shared constants and the YU limiter for the quantizer scale factor adaptation stages.
package qsf_pkg;

  localparam int unsigned YU_W = 13;
  localparam int unsigned YL_W = 19;

  localparam logic [YU_W-1:0] YU_MIN = 13'd544;
  localparam logic [YU_W-1:0] YU_MAX = 13'd5120;
  localparam logic [YU_W-1:0] YU_RST = 13'd544;
  localparam logic [YL_W-1:0] YL_RST = 19'd34816;

  function automatic logic [YU_W-1:0] qsf_limit(input logic [YU_W-1:0] yut);
    if (yut < YU_MIN)      return YU_MIN;
    else if (yut > YU_MAX) return YU_MAX;
    else                   return yut;
  endfunction

endpackage

// File: rtl/qsf_ylfilt.sv
// Combinational LIMB + FILTE: limits YUT to YUL and low-pass filters YL towards YUL<<6.
module qsf_ylfilt
  import qsf_pkg::*;
(
  input  logic [YU_W-1:0] yut,
  input  logic [YL_W-1:0] yl,
  output logic [YU_W-1:0] yul,
  output logic [YL_W-1:0] ylp
);

  logic [YL_W:0] diff;
  logic [YL_W:0] step;

  always_comb begin
    yul  = qsf_limit(yut);
    diff = {1'b0, yul, 6'b0} - {1'b0, yl};
    // arithmetic shift floors negative differences; the sum wraps mod 2^19
    step = $signed(diff) >>> 6;
    ylp  = yl + step[YL_W-1:0];
  end

endmodule

// File: rtl/qsf_state_store.sv
// Per-channel YU/YL store with a 2-stage update pipeline, an init port and a registered read port.
module qsf_state_store
  import qsf_pkg::*;
#(
  parameter int unsigned NCH = 32,
  parameter int unsigned CW  = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            upd_valid,
  input  logic [CW-1:0]   upd_chan,
  input  logic [12:0]     YUT,
  input  logic            init_req,
  input  logic [CW-1:0]   init_chan,
  input  logic            rd_valid,
  input  logic [CW-1:0]   rd_chan,
  output logic [12:0]     YU,
  output logic [18:0]     YL,
  output logic            rd_done,
  output logic            upd_done
);

  logic [YU_W-1:0] yu_mem_q [NCH];
  logic [YU_W-1:0] yu_mem_d [NCH];
  logic [YL_W-1:0] yl_mem_q [NCH];
  logic [YL_W-1:0] yl_mem_d [NCH];

  logic            pipe_valid_q, pipe_valid_d;
  logic [CW-1:0]   pipe_chan_q,  pipe_chan_d;
  logic [YU_W-1:0] pipe_yul_q,   pipe_yul_d;

  logic [YU_W-1:0] yu_q, yu_d;
  logic [YL_W-1:0] yl_q, yl_d;
  logic            rd_done_q, rd_done_d;

  logic            upd_ok, init_ok, rd_ok;
  logic [YU_W-1:0] s2_yul;
  logic [YL_W-1:0] s2_ylp;

  // S2 arithmetic; the stage register already holds a limited value, so re-limiting is a no-op
  qsf_ylfilt u_ylfilt (
    .yut (pipe_yul_q),
    .yl  (yl_mem_q[pipe_chan_q]),
    .yul (s2_yul),
    .ylp (s2_ylp)
  );

  always_comb begin
    upd_ok  = 32'(upd_chan)  < NCH;
    init_ok = 32'(init_chan) < NCH;
    rd_ok   = 32'(rd_chan)   < NCH;

    pipe_valid_d = upd_valid && upd_ok;
    pipe_chan_d  = upd_chan;
    pipe_yul_d   = qsf_limit(YUT);

    yu_mem_d = yu_mem_q;
    yl_mem_d = yl_mem_q;
    if (pipe_valid_q) begin
      yu_mem_d[pipe_chan_q] = s2_yul;
      yl_mem_d[pipe_chan_q] = s2_ylp;
    end
    // init is applied last so it wins over an S2 write to the same channel
    if (init_req && init_ok) begin
      yu_mem_d[init_chan] = YU_RST;
      yl_mem_d[init_chan] = YL_RST;
    end

    rd_done_d = rd_valid;
    yu_d      = yu_q;
    yl_d      = yl_q;
    if (rd_valid) begin
      yu_d = rd_ok ? yu_mem_q[rd_chan] : '0;
      yl_d = rd_ok ? yl_mem_q[rd_chan] : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NCH; i++) begin
        yu_mem_q[i] <= YU_RST;
        yl_mem_q[i] <= YL_RST;
      end
      pipe_valid_q <= 1'b0;
      pipe_chan_q  <= '0;
      pipe_yul_q   <= '0;
      yu_q         <= '0;
      yl_q         <= '0;
      rd_done_q    <= 1'b0;
    end else begin
      yu_mem_q     <= yu_mem_d;
      yl_mem_q     <= yl_mem_d;
      pipe_valid_q <= pipe_valid_d;
      pipe_chan_q  <= pipe_chan_d;
      pipe_yul_q   <= pipe_yul_d;
      yu_q         <= yu_d;
      yl_q         <= yl_d;
      rd_done_q    <= rd_done_d;
    end
  end

  assign YU       = yu_q;
  assign YL       = yl_q;
  assign rd_done  = rd_done_q;
  assign upd_done = pipe_valid_q;

endmodule

// File: tb/tb_qsf_state_store.sv
// Self-checking bench for qsf_state_store: directed scenarios plus a random phase against a per-channel model.
module tb_qsf_state_store;

  logic        clk;
  logic        reset;
  logic        upd_valid;
  logic [4:0]  upd_chan;
  logic [12:0] YUT;
  logic        init_req;
  logic [4:0]  init_chan;
  logic        rd_valid;
  logic [4:0]  rd_chan;
  logic [12:0] YU;
  logic [18:0] YL;
  logic        rd_done;
  logic        upd_done;

  qsf_state_store #(.NCH(32), .CW(5)) dut (
    .clk       (clk),
    .reset     (reset),
    .upd_valid (upd_valid),
    .upd_chan  (upd_chan),
    .YUT       (YUT),
    .init_req  (init_req),
    .init_chan (init_chan),
    .rd_valid  (rd_valid),
    .rd_chan   (rd_chan),
    .YU        (YU),
    .YL        (YL),
    .rd_done   (rd_done),
    .upd_done  (upd_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int m_yu [32];
  int m_yl [32];
  bit p_v;
  int p_ch, p_yul;
  bit e_rd_done, e_upd;
  int e_yu, e_yl;

  function automatic int lim(input int x);
    if (x < 544)  return 544;
    if (x > 5120) return 5120;
    return x;
  endfunction

  // YL + floor((YUL*64 - YL)/64), wrapped to 19 bits
  function automatic int filt(input int yl, input int yul);
    int d, q;
    d = yul * 64 - yl;
    q = (d >= 0) ? d / 64 : -((-d + 63) / 64);
    return (yl + q) % 524288;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        m_yu[i] = 544;
        m_yl[i] = 34816;
      end
      p_v = 0; e_rd_done = 0; e_upd = 0; e_yu = 0; e_yl = 0;
    end else begin
      e_rd_done = rd_valid;
      if (rd_valid) begin
        e_yu = m_yu[rd_chan];
        e_yl = m_yl[rd_chan];
      end
      if (p_v) begin
        m_yl[p_ch] = filt(m_yl[p_ch], p_yul);
        m_yu[p_ch] = p_yul;
      end
      if (init_req) begin
        m_yu[init_chan] = 544;
        m_yl[init_chan] = 34816;
      end
      p_v   = upd_valid;
      p_ch  = upd_chan;
      p_yul = lim(int'(YUT));
      e_upd = p_v;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc_rd_done",  {31'd0, rd_done},  {31'd0, e_rd_done});
      check("cyc_upd_done", {31'd0, upd_done}, {31'd0, e_upd});
      check("cyc_YU", {19'd0, YU}, e_yu);
      check("cyc_YL", {13'd0, YL}, e_yl);
    end
  end

  // ---------------- directed helpers ----------------
  task automatic rd(input int ch, input int eyu, input int eyl, input string nm);
    rd_valid = 1'b1;
    rd_chan  = 5'(ch);
    @(negedge clk);
    rd_valid = 1'b0;
    check({nm, "_rd_done"}, {31'd0, rd_done}, 32'd1);
    check({nm, "_YU"}, {19'd0, YU}, eyu);
    check({nm, "_YL"}, {13'd0, YL}, eyl);
  endtask

  task automatic upd(input int ch, input int yut);
    upd_valid = 1'b1;
    upd_chan  = 5'(ch);
    YUT       = 13'(yut);
    @(negedge clk);
    upd_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; upd_valid = 1'b0; upd_chan = '0; YUT = '0;
    init_req = 1'b0; init_chan = '0; rd_valid = 1'b0; rd_chan = '0;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    check("rst_YU", {19'd0, YU}, 32'd0);
    check("rst_YL", {13'd0, YL}, 32'd0);
    check("rst_rd_done", {31'd0, rd_done}, 32'd0);
    check("rst_upd_done", {31'd0, upd_done}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // 1: reset values at both ends of the channel range
    rd(0, 544, 34816, "t1_ch0");
    rd(31, 544, 34816, "t1_ch31");
    @(negedge clk);
    check("t1_rd_done_drop", {31'd0, rd_done}, 32'd0);
    check("t1_YU_hold", {19'd0, YU}, 32'd544);

    // 2: clamp low leaves YL unchanged
    upd(3, 100);
    check("t2_upd_done", {31'd0, upd_done}, 32'd1);
    @(negedge clk);
    rd(3, 544, 34816, "t2");

    // 3: clamp high, then back-to-back negative step on the same channel
    upd_valid = 1'b1; upd_chan = 5'd3; YUT = 13'd6000;
    @(negedge clk);
    YUT = 13'd544;
    @(negedge clk);
    upd_valid = 1'b0;
    rd(3, 5120, 39392, "t3_first");
    rd(3, 544, 39320, "t3_second");

    // 4: read during S2 returns the old state
    upd(5, 2000);
    rd(5, 544, 34816, "t4_old");
    rd(5, 2000, 36272, "t4_new");

    // 5: init beats the S2 write to the same channel
    upd(5, 4000);
    init_req = 1'b1; init_chan = 5'd5;
    check("t5_upd_done", {31'd0, upd_done}, 32'd1);
    @(negedge clk);
    init_req = 1'b0;
    rd(5, 544, 34816, "t5");

    // 6: reset discards an in-flight update
    reset = 1'b1;
    upd(7, 3000);
    reset = 1'b0;
    check("t6_no_upd_done", {31'd0, upd_done}, 32'd0);
    @(negedge clk);
    check("t6_no_upd_done2", {31'd0, upd_done}, 32'd0);
    rd(7, 544, 34816, "t6");

    // random traffic, concentrated on a few channels to provoke collisions
    for (int i = 0; i < 10000; i++) begin
      upd_valid = 1'($urandom_range(0, 1));
      upd_chan  = 5'($urandom_range(0, 7));
      YUT       = 13'($urandom_range(0, 8191));
      init_req  = ($urandom_range(0, 15) == 0);
      init_chan = 5'($urandom_range(0, 7));
      rd_valid  = 1'($urandom_range(0, 1));
      rd_chan   = 5'($urandom_range(0, 7));
      @(negedge clk);
    end
    upd_valid = 1'b0; init_req = 1'b0; rd_valid = 1'b0;
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
